ir_nec_decoder: RTL and testbench

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_nec_pkg.sv | 35 +++
 rtl/ir_interval_timer.sv | 41 ++++
 rtl/ir_nec_decoder.sv | 141 ++++++++++++++
 tb/tb_ir_nec_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC infrared decoder.
//   state_e    : decoder FSM states
//   cls_e      : classification of a measured mark-to-mark interval
//   *_MIN/MAX  : inclusive interval windows, in 10 us ticks
//   CNT_SAT    : saturation value of the interval counter (timeout)
//   classify() : maps an interval count to its class
package ir_nec_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CHECK} state_e;

  typedef enum logic [2:0] {C_LEADER, C_REPEAT, C_BIT0, C_BIT1, C_OTHER} cls_e;

  localparam int          CNT_W    = 11;
  localparam logic [10:0] CNT_SAT  = 11'd2047;

  localparam logic [10:0] LEAD_MIN = 11'd1250;
  localparam logic [10:0] LEAD_MAX = 11'd1450;
  localparam logic [10:0] REP_MIN  = 11'd1050;
  localparam logic [10:0] REP_MAX  = 11'd1200;
  localparam logic [10:0] BIT0_MIN = 11'd90;
  localparam logic [10:0] BIT0_MAX = 11'd135;
  localparam logic [10:0] BIT1_MIN = 11'd190;
  localparam logic [10:0] BIT1_MAX = 11'd260;

  function automatic cls_e classify(input logic [10:0] t);
    cls_e c;
    c = C_OTHER;
    if      (t >= LEAD_MIN && t <= LEAD_MAX) c = C_LEADER;
    else if (t >= REP_MIN  && t <= REP_MAX)  c = C_REPEAT;
    else if (t >= BIT0_MIN && t <= BIT0_MAX) c = C_BIT0;
    else if (t >= BIT1_MIN && t <= BIT1_MAX) c = C_BIT1;
    return c;
  endfunction

endpackage

// File: rtl/ir_interval_timer.sv
// Measures time since the last IR mark edge in 10 us ticks.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clr     : restart measurement (pos_edge); clears prescaler and counter
//   count   : ticks elapsed since last clr, saturating at CNT_SAT
//   timeout : count has saturated
module ir_interval_timer
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    pre_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // clr has priority, so a tick landing on the edge cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick && cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign count   = cnt_q;
  assign timeout = (cnt_q == CNT_SAT);

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder driven by mark-start edge pulses.
//   clk      : clock (all logic on rising edge)
//   rst      : synchronous active-high reset
//   pos_edge : one-cycle pulse at the start of every IR mark burst
//   addr     : address byte of the last valid frame
//   cmd      : command byte of the last valid frame
//   valid    : one-cycle pulse, new frame decoded (addr/cmd updated same cycle)
//   rep      : one-cycle pulse, repeat code following a valid frame
//   err      : one-cycle pulse, malformed or timed-out frame
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV = 120,
  parameter int CHK_ADDR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pos_edge,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       rep,
  output logic       err
);

  logic [CNT_W-1:0] ivl;
  logic             tmo;
  cls_e             cls;

  ir_interval_timer #(.TICK_DIV(TICK_DIV)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (pos_edge),
    .count   (ivl),
    .timeout (tmo)
  );

  assign cls = classify(ivl);

  state_e      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic        have_q, have_d;
  logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;
  logic        valid_q, valid_d, rep_q, rep_d, err_q, err_d;
  logic        pass;

  // Frame layout on air, LSB first: addr, ~addr, cmd, ~cmd.
  assign pass = (sr_q[23:16] == ~sr_q[31:24]) &&
                ((CHK_ADDR == 0) || (sr_q[7:0] == ~sr_q[15:8]));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    have_d  = have_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
    rep_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (pos_edge) state_d = S_SYNC;
      S_SYNC: begin
        // Unrecognised intervals simply re-arm on the new edge.
        if (pos_edge) begin
          if (cls == C_LEADER) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else if (cls == C_REPEAT) begin
            rep_d = have_q;
          end
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (pos_edge) begin
          if (cls == C_BIT0 || cls == C_BIT1) begin
            sr_d   = {cls == C_BIT1, sr_q[31:1]};
            bcnt_d = bcnt_q + 5'd1;
            if (bcnt_q == 5'd31) state_d = S_CHECK;
          end else begin
            err_d   = 1'b1;
            have_d  = 1'b0;
            state_d = S_SYNC;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          have_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        // An edge here only restarts the timer; SYNC is next either way.
        if (pass) begin
          addr_d  = sr_q[7:0];
          cmd_d   = sr_q[23:16];
          valid_d = 1'b1;
          have_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
          have_d = 1'b0;
        end
        state_d = S_SYNC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      have_q  <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      have_q  <= have_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  assign addr  = addr_q;
  assign cmd   = cmd_q;
  assign valid = valid_q;
  assign rep   = rep_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: one DUT with address checking and one
// in extended mode share the same edge stream.
module tb_ir_nec_decoder;
  import ir_nec_pkg::*;

  localparam int TD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pos_edge = 1'b0;
  logic [7:0] addr, cmd, x_addr, x_cmd;
  logic       valid, rep, err, x_valid, x_rep, x_err;

  ir_nec_decoder #(.TICK_DIV(TD), .CHK_ADDR(1)) dut (
    .clk(clk), .rst(rst), .pos_edge(pos_edge),
    .addr(addr), .cmd(cmd), .valid(valid), .rep(rep), .err(err));

  ir_nec_decoder #(.TICK_DIV(TD), .CHK_ADDR(0)) dut_x (
    .clk(clk), .rst(rst), .pos_edge(pos_edge),
    .addr(x_addr), .cmd(x_cmd), .valid(x_valid), .rep(x_rep), .err(x_err));

  always #5 clk = ~clk;

  // Cycles each pulse output is high; an event must add exactly one.
  int nv = 0, nr = 0, ne = 0, xv = 0, xr = 0, xe = 0, nmulti = 0;
  always @(negedge clk) begin
    if (valid)   nv++;
    if (rep)     nr++;
    if (err)     ne++;
    if (x_valid) xv++;
    if (x_rep)   xr++;
    if (x_err)   xe++;
    if (int'(valid) + int'(rep) + int'(err) > 1 ||
        int'(x_valid) + int'(x_rep) + int'(x_err) > 1) nmulti++;
  end

  int pass_cnt = 0, total = 0;
  int v0, r0, e0, xv0, xr0, xe0;

  task automatic snap();
    v0 = nv; r0 = nr; e0 = ne; xv0 = xv; xr0 = xr; xe0 = xe;
  endtask

  // Edge pulse 'ticks' ticks after the previous one.
  task automatic gap(input int ticks);
    repeat (ticks * TD - 1) @(negedge clk);
    pos_edge = 1'b1;
    @(negedge clk);
    pos_edge = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) gap(w[i] ? 225 : 112);
  endtask

  task automatic send_frame(input logic [31:0] w);
    gap(300);
    gap(1350);
    send_bits(w, 32);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (addr !== 8'h00) $display("FAIL rst_addr got %h want 00", addr); else pass_cnt++;
    total++; if (cmd !== 8'h00) $display("FAIL rst_cmd got %h want 00", cmd); else pass_cnt++;
    total++; if ({valid, rep, err} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {valid, rep, err}); else pass_cnt++;
    total++; if (dut.state_q !== S_IDLE) $display("FAIL rst_state got %0d want %0d", dut.state_q, S_IDLE); else pass_cnt++;
    total++; if (dut.u_tmr.count !== 11'd0) $display("FAIL rst_count got %0d want 0", dut.u_tmr.count); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 0xE51A0077: cmd pair inverted, addr pair not.
  task automatic test_frame_ext();
    snap();
    send_frame(32'hE51A0077);
    total++; if (nv - v0 !== 0) $display("FAIL ext_valid_chk got %0d want 0", nv - v0); else pass_cnt++;
    total++; if (ne - e0 !== 1) $display("FAIL ext_err_chk got %0d want 1", ne - e0); else pass_cnt++;
    total++; if (addr !== 8'h00) $display("FAIL ext_addr_chk got %h want 00", addr); else pass_cnt++;
    total++; if (xv - xv0 !== 1) $display("FAIL ext_valid got %0d want 1", xv - xv0); else pass_cnt++;
    total++; if (xe - xe0 !== 0) $display("FAIL ext_err got %0d want 0", xe - xe0); else pass_cnt++;
    total++; if (x_addr !== 8'h77) $display("FAIL ext_addr got %h want 77", x_addr); else pass_cnt++;
    total++; if (x_cmd !== 8'h1A) $display("FAIL ext_cmd got %h want 1a", x_cmd); else pass_cnt++;
    total++; if (dut.state_q !== S_SYNC) $display("FAIL ext_state got %0d want %0d", dut.state_q, S_SYNC); else pass_cnt++;
  endtask

  // Only the extended-mode decoder holds a frame, so only it repeats.
  task automatic test_repeat();
    snap();
    repeat (2100 * TD) @(negedge clk);
    total++; if (dut_x.state_q !== S_IDLE) $display("FAIL rep_timeout_state got %0d want %0d", dut_x.state_q, S_IDLE); else pass_cnt++;
    total++; if (xe - xe0 !== 0) $display("FAIL rep_timeout_err got %0d want 0", xe - xe0); else pass_cnt++;
    gap(1);
    gap(1125);
    repeat (3) @(negedge clk);
    total++; if (xr - xr0 !== 1) $display("FAIL rep_pulse got %0d want 1", xr - xr0); else pass_cnt++;
    total++; if (nr - r0 !== 0) $display("FAIL rep_no_frame got %0d want 0", nr - r0); else pass_cnt++;
    total++; if (x_addr !== 8'h77) $display("FAIL rep_addr got %h want 77", x_addr); else pass_cnt++;
  endtask

  task automatic test_bit_error();
    snap();
    gap(300);
    gap(1350);
    send_bits(32'h0, 5);
    gap(160);
    repeat (3) @(negedge clk);
    total++; if (ne - e0 !== 1) $display("FAIL biterr_err got %0d want 1", ne - e0); else pass_cnt++;
    total++; if (xe - xe0 !== 1) $display("FAIL biterr_x_err got %0d want 1", xe - xe0); else pass_cnt++;
    total++; if (dut.state_q !== S_SYNC) $display("FAIL biterr_state got %0d want %0d", dut.state_q, S_SYNC); else pass_cnt++;
    total++; if ({x_addr, x_cmd} !== 16'h771A) $display("FAIL biterr_hold got %h want 771a", {x_addr, x_cmd}); else pass_cnt++;
    total++; if (xv - xv0 !== 0) $display("FAIL biterr_valid got %0d want 0", xv - xv0); else pass_cnt++;
  endtask

  // cmd_n equals cmd (both 0x00); addr pair is good.
  task automatic test_cmd_check();
    snap();
    send_frame(32'h0000FF00);
    total++; if (ne - e0 !== 1) $display("FAIL cmdchk_err got %0d want 1", ne - e0); else pass_cnt++;
    total++; if (xe - xe0 !== 1) $display("FAIL cmdchk_x_err got %0d want 1", xe - xe0); else pass_cnt++;
    total++; if (nv - v0 + xv - xv0 !== 0) $display("FAIL cmdchk_valid got %0d want 0", nv - v0 + xv - xv0); else pass_cnt++;
    total++; if (x_cmd !== 8'h1A) $display("FAIL cmdchk_hold got %h want 1a", x_cmd); else pass_cnt++;
  endtask

  task automatic test_timeout();
    snap();
    gap(300);
    gap(1350);
    send_bits(32'h155, 10);
    repeat (2040 * TD) @(negedge clk);
    total++; if (ne - e0 !== 0) $display("FAIL tmo_early got %0d want 0", ne - e0); else pass_cnt++;
    total++; if (dut.state_q !== S_DATA) $display("FAIL tmo_early_state got %0d want %0d", dut.state_q, S_DATA); else pass_cnt++;
    repeat (20 * TD) @(negedge clk);
    total++; if (ne - e0 !== 1) $display("FAIL tmo_err got %0d want 1", ne - e0); else pass_cnt++;
    total++; if (xe - xe0 !== 1) $display("FAIL tmo_x_err got %0d want 1", xe - xe0); else pass_cnt++;
    total++; if (dut.state_q !== S_IDLE) $display("FAIL tmo_state got %0d want %0d", dut.state_q, S_IDLE); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    gap(300);
    gap(1350);
    send_bits(32'hCB34ED12, 20);
    snap();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (nv - v0 + nr - r0 + ne - e0 + xe - xe0 !== 0) $display("FAIL rstmid_pulses got %0d want 0", nv - v0 + nr - r0 + ne - e0 + xe - xe0); else pass_cnt++;
    total++; if ({x_addr, x_cmd} !== 16'h0000) $display("FAIL rstmid_out got %h want 0000", {x_addr, x_cmd}); else pass_cnt++;
    total++; if (dut.state_q !== S_IDLE) $display("FAIL rstmid_state got %0d want %0d", dut.state_q, S_IDLE); else pass_cnt++;
    gap(300);
    total++; if (dut.state_q !== S_SYNC) $display("FAIL rstmid_sync got %0d want %0d", dut.state_q, S_SYNC); else pass_cnt++;
    gap(1125);
    repeat (3) @(negedge clk);
    total++; if (xr - xr0 + nr - r0 !== 0) $display("FAIL rstmid_no_rep got %0d want 0", xr - xr0 + nr - r0); else pass_cnt++;
    send_frame(32'hCB34ED12);
    total++; if (nv - v0 !== 1) $display("FAIL rstmid_valid got %0d want 1", nv - v0); else pass_cnt++;
    total++; if ({addr, cmd} !== 16'h1234) $display("FAIL rstmid_data got %h want 1234", {addr, cmd}); else pass_cnt++;
    total++; if (ne - e0 !== 0) $display("FAIL rstmid_err got %0d want 0", ne - e0); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame_ext();
    test_repeat();
    test_bit_error();
    test_cmd_check();
    test_timeout();
    test_reset_mid();
    total++; if (nmulti !== 0) $display("FAIL exclusive got %0d want 0", nmulti); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
